// File: rtl/pps_div_bus_arbiter_pkg.sv
// Shared types and constants for the pps divider register-bus arbiter.
// State encodings are fixed values so bench and tooling can decode them.
package pps_div_bus_arbiter_pkg;

  localparam int ADDR_WIDTH = 8;
  localparam int DATA_WIDTH = 8;

  // Bytes of the 24-bit phase field, written atomically under lock.
  localparam logic [ADDR_WIDTH-1:0] REG_PHASE_0 = 8'h04;
  localparam logic [ADDR_WIDTH-1:0] REG_PHASE_1 = 8'h05;
  localparam logic [ADDR_WIDTH-1:0] REG_PHASE_2 = 8'h06;

  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_XFER   = 3'd1,
    S_RWAIT  = 3'd2,
    S_RDONE  = 3'd3,
    S_LOCKED = 3'd4
  } state_e;

  typedef enum logic [1:0] {
    OWN_NONE = 2'd0,
    OWN_A    = 2'd1,
    OWN_B    = 2'd2
  } owner_e;

  typedef struct packed {
    logic                  wr;
    logic                  lock;
    logic [ADDR_WIDTH-1:0] addr;
    logic [DATA_WIDTH-1:0] wdata;
  } req_t;

  // A transaction is in flight in these states; LOCKED with no access is not busy.
  function automatic logic state_is_busy(input state_e s);
    return (s == S_XFER) || (s == S_RWAIT) || (s == S_RDONE);
  endfunction

endpackage

// File: rtl/pps_div_rr_pick.sv
// Two-way round-robin selector: on a tie the port not served last wins.
module pps_div_rr_pick (
  input  logic req_a,
  input  logic req_b,
  input  logic last_served,  // 1 = port B was served last
  output logic grant_a,
  output logic grant_b
);

  assign grant_a = req_a & (~req_b | last_served);
  assign grant_b = req_b & (~req_a | ~last_served);

endmodule

// File: rtl/pps_div_bus_arbiter.sv
// Shares the pps divider register bus between the SPI (A) and UART (B) hosts,
// absorbing the bank's one-cycle registered read and supporting locked bursts.
module pps_div_bus_arbiter
  import pps_div_bus_arbiter_pkg::*;
#(
  parameter int LOCK_TIMEOUT = 16,
  parameter int TO_WIDTH     = 8
) (
  input  logic                  i_clk_10,
  input  logic                  i_rst_n,
  input  logic                  i_a_req,
  input  logic                  i_a_wr,
  input  logic                  i_a_lock,
  input  logic [ADDR_WIDTH-1:0] i_a_addr,
  input  logic [DATA_WIDTH-1:0] i_a_wdata,
  output logic                  o_a_ack,
  output logic [DATA_WIDTH-1:0] o_a_rdata,
  input  logic                  i_b_req,
  input  logic                  i_b_wr,
  input  logic                  i_b_lock,
  input  logic [ADDR_WIDTH-1:0] i_b_addr,
  input  logic [DATA_WIDTH-1:0] i_b_wdata,
  output logic                  o_b_ack,
  output logic [DATA_WIDTH-1:0] o_b_rdata,
  output logic [ADDR_WIDTH-1:0] o_addr,
  output logic [DATA_WIDTH-1:0] o_data,
  output logic                  o_wr,
  input  logic [DATA_WIDTH-1:0] i_rdata,
  output logic                  o_busy
);

  state_e                state_q, state_d;
  owner_e                owner_q, owner_d;
  logic                  last_b_q, last_b_d;
  logic                  lock_q, lock_d;
  logic [TO_WIDTH-1:0]   to_cnt_q, to_cnt_d;
  logic [ADDR_WIDTH-1:0] addr_q, addr_d;
  logic [DATA_WIDTH-1:0] data_q, data_d;
  logic                  wr_q, wr_d;
  logic                  a_ack_q, a_ack_d;
  logic                  b_ack_q, b_ack_d;
  logic [DATA_WIDTH-1:0] a_rdata_q, a_rdata_d;
  logic [DATA_WIDTH-1:0] b_rdata_q, b_rdata_d;
  logic                  busy_q, busy_d;

  logic grant_a, grant_b;
  logic start_a, start_b, done;
  req_t a_fields, b_fields, sel;

  assign a_fields = '{wr: i_a_wr, lock: i_a_lock, addr: i_a_addr, wdata: i_a_wdata};
  assign b_fields = '{wr: i_b_wr, lock: i_b_lock, addr: i_b_addr, wdata: i_b_wdata};

  pps_div_rr_pick u_rr_pick (
    .req_a       (i_a_req),
    .req_b       (i_b_req),
    .last_served (last_b_q),
    .grant_a     (grant_a),
    .grant_b     (grant_b)
  );

  always_comb begin
    // NOTE: every variable gets a default first so no path through this block infers a latch.
    state_d   = state_q;
    owner_d   = owner_q;
    last_b_d  = last_b_q;
    lock_d    = lock_q;
    to_cnt_d  = to_cnt_q;
    addr_d    = addr_q;
    data_d    = data_q;
    a_rdata_d = a_rdata_q;
    b_rdata_d = b_rdata_q;
    wr_d      = 1'b0;
    a_ack_d   = 1'b0;
    b_ack_d   = 1'b0;
    start_a   = 1'b0;
    start_b   = 1'b0;
    sel       = a_fields;

    case (state_q)
      S_IDLE: begin
        start_a = grant_a;
        start_b = grant_b;
      end
      S_XFER: begin
        if (!wr_q) state_d = S_RWAIT;
      end
      S_RWAIT: begin
        // Bank data registered during XFER is valid now; publish it with the ack.
        if (owner_q == OWN_A) a_rdata_d = i_rdata;
        if (owner_q == OWN_B) b_rdata_d = i_rdata;
        a_ack_d = (owner_q == OWN_A);
        b_ack_d = (owner_q == OWN_B);
        state_d = S_RDONE;
      end
      S_RDONE: begin
      end
      S_LOCKED: begin
        start_a = (owner_q == OWN_A) && i_a_req;
        start_b = (owner_q == OWN_B) && i_b_req;
        if (!(start_a || start_b)) begin
          to_cnt_d = to_cnt_q + TO_WIDTH'(1);
          if (to_cnt_d == TO_WIDTH'(LOCK_TIMEOUT)) begin
            state_d  = S_IDLE;
            owner_d  = OWN_NONE;
            to_cnt_d = '0;
          end
        end
      end
      default: state_d = S_IDLE;
    endcase

    // The ack cycle of the current transaction: write in XFER, read in RDONE.
    done = ((state_q == S_XFER) && wr_q) || (state_q == S_RDONE);
    if (done) begin
      last_b_d = (owner_q == OWN_B);
      if (lock_q) begin
        state_d  = S_LOCKED;
        to_cnt_d = '0;
      end else begin
        state_d = S_IDLE;
        owner_d = OWN_NONE;
      end
    end

    if (start_a || start_b) begin
      sel      = start_b ? b_fields : a_fields;
      state_d  = S_XFER;
      owner_d  = start_b ? OWN_B : OWN_A;
      addr_d   = sel.addr;
      data_d   = sel.wdata;
      wr_d     = sel.wr;
      lock_d   = sel.lock;
      to_cnt_d = '0;
      a_ack_d  = start_a && sel.wr;
      b_ack_d  = start_b && sel.wr;
    end

    busy_d = state_is_busy(state_d);
  end

  // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge i_clk_10 or negedge i_rst_n) begin
    if (!i_rst_n) begin
      state_q   <= S_IDLE;
      owner_q   <= OWN_NONE;
      last_b_q  <= 1'b1;
      lock_q    <= 1'b0;
      to_cnt_q  <= '0;
      addr_q    <= '0;
      data_q    <= '0;
      wr_q      <= 1'b0;
      a_ack_q   <= 1'b0;
      b_ack_q   <= 1'b0;
      a_rdata_q <= '0;
      b_rdata_q <= '0;
      busy_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      owner_q   <= owner_d;
      last_b_q  <= last_b_d;
      lock_q    <= lock_d;
      to_cnt_q  <= to_cnt_d;
      addr_q    <= addr_d;
      data_q    <= data_d;
      wr_q      <= wr_d;
      a_ack_q   <= a_ack_d;
      b_ack_q   <= b_ack_d;
      a_rdata_q <= a_rdata_d;
      b_rdata_q <= b_rdata_d;
      busy_q    <= busy_d;
    end
  end

  assign o_addr    = addr_q;
  assign o_data    = data_q;
  assign o_wr      = wr_q;
  assign o_a_ack   = a_ack_q;
  assign o_b_ack   = b_ack_q;
  assign o_a_rdata = a_rdata_q;
  assign o_b_rdata = b_rdata_q;
  assign o_busy    = busy_q;

endmodule
